pong_renderer: RTL and testbench

PONG_RENDERER -- requirements
Module: pong_renderer

---
 rtl/pong_renderer.sv | 118 +++++++++++
 tb/tb_pong_renderer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pong_renderer.sv
// VGA-style Pong frame renderer: raster counters, sync generation and a
// per-pixel colour mux fed from a once-per-frame snapshot of the game state.
module pong_renderer #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int PAD_WIDTH    = 8,
  parameter int PAD_HEIGHT   = 64,
  parameter int PAD_DISTANCE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [11:0] pad_left,
  input  logic [11:0] pad_right,
  input  logic [11:0] ball_x,
  input  logic [11:0] ball_y,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  rgb,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic signed [13:0] ONE   = 14'sd1;
  localparam logic signed [13:0] HALF  = 14'(PAD_HEIGHT / 2);
  localparam logic signed [13:0] LP_X0 = 14'(PAD_DISTANCE);
  localparam logic signed [13:0] LP_X1 = 14'(PAD_DISTANCE + PAD_WIDTH - 1);
  localparam logic signed [13:0] RP_X0 = 14'(H_ACTIVE - PAD_DISTANCE - PAD_WIDTH);
  localparam logic signed [13:0] RP_X1 = 14'(H_ACTIVE - PAD_DISTANCE - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [11:0]   pl_q, pr_q, bx_q, by_q;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          latch_hit;

  assign latch_hit   = (h_q == '0) && (v_q == VW'(V_ACTIVE));
  assign frame_start = pix_en && !rst && latch_hit;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HW'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end
  end

  // Game space: 14-bit signed so pad/ball bounds near the edges never wrap.
  logic signed [13:0] x_s, y_s, plc, prc, bxc, byc;
  logic               in_lpad, in_rpad, in_ball, in_net, active;

  always_comb begin
    x_s = $signed(14'(h_q));
    y_s = $signed(14'(V_ACTIVE - 1)) - $signed(14'(v_q));
    plc = $signed({2'b00, pl_q});
    prc = $signed({2'b00, pr_q});
    bxc = $signed({2'b00, bx_q});
    byc = $signed({2'b00, by_q});

    in_lpad = (x_s >= LP_X0) && (x_s <= LP_X1) && (y_s >= plc - HALF) && (y_s <= plc + HALF);
    in_rpad = (x_s >= RP_X0) && (x_s <= RP_X1) && (y_s >= prc - HALF) && (y_s <= prc + HALF);
    in_ball = (x_s >= bxc - ONE) && (x_s <= bxc + ONE) && (y_s >= byc - ONE) && (y_s <= byc + ONE);
    in_net  = (h_q == HW'(H_ACTIVE / 2)) && !v_q[3];
    active  = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));

    rgb_d = 3'b000;
    if (active) begin
      if (in_ball)                 rgb_d = 3'b110;
      else if (in_lpad || in_rpad) rgb_d = 3'b111;
      else if (in_net)             rgb_d = 3'b010;
    end

    hs_d = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vs_d = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= 3'b000;
      // Reset snapshot centres everything on screen (240/320/240 at defaults).
      pl_q  <= 12'(V_ACTIVE / 2);
      pr_q  <= 12'(V_ACTIVE / 2);
      bx_q  <= 12'(H_ACTIVE / 2);
      by_q  <= 12'(V_ACTIVE / 2);
    end else if (pix_en) begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      if (latch_hit) begin
        pl_q <= pad_left;
        pr_q <= pad_right;
        bx_q <= ball_x;
        by_q <= ball_y;
      end
    end
  end

  assign hsync = hs_q;
  assign vsync = vs_q;
  assign rgb   = rgb_q;
endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer on a reduced 80x55 raster (64x48 visible)
// so several whole frames fit in a short run.
module tb_pong_renderer;
  localparam int HT = 80;
  localparam int VT = 55;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic [11:0] pad_left = 12'd0, pad_right = 12'd0, ball_x = 12'd0, ball_y = 12'd0;
  logic        hsync, vsync, frame_start;
  logic [2:0]  rgb;

  pong_renderer #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .PAD_WIDTH(4), .PAD_HEIGHT(8), .PAD_DISTANCE(4)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .pad_left(pad_left), .pad_right(pad_right), .ball_x(ball_x), .ball_y(ball_y),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         v;
    int         h;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;
  int   errors = 0;
  int   checks = 0;
  int   mh = 0, mv = 0;

  function automatic void add(int v, int h, logic [2:0] c, logic hs, logic vs);
    vecs[nvec] = '{v: v, h: h, rgb: c, hs: hs, vs: vs};
    nvec++;
  endfunction

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at v=%0d h=%0d: got %0d expected %0d", nm, mv, mh, got, exp);
    end
  endtask

  // One pixel-enabled clock; model counters follow the raster.
  task automatic pix();
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
  endtask

  task automatic step_to(int v, int h);
    int n = 0;
    while (!(mv == v && mh == h)) begin
      if (mv == 48 && mh == 0) begin
        pix_en = 1'b0;
        #1 chk("frame_start_gated", int'(frame_start), 0);
        pix_en = 1'b1;
        #1 chk("frame_start_pulse", int'(frame_start), 1);
      end else if (mv == 48 && mh == 1) begin
        chk("frame_start_low", int'(frame_start), 0);
      end
      pix();
      n++;
      if (n > 5000) begin
        chk("step_timeout", n, 0);
        return;
      end
    end
  endtask

  task automatic run_vec(int a, int b);
    for (int i = a; i < b; i++) begin
      step_to(vecs[i].v, vecs[i].h);
      pix();
      chk($sformatf("rgb[%0d]", i), int'(rgb), int'(vecs[i].rgb));
      chk($sformatf("hsync[%0d]", i), int'(hsync), int'(vecs[i].hs));
      chk($sformatf("vsync[%0d]", i), int'(vsync), int'(vecs[i].vs));
    end
  endtask

  initial begin
    int f1, f1b, f2a, f2b, f2c, f3;
    logic [2:0] frz_rgb;
    // Frame 0: reset snapshot, pads 24, ball (32,24)
    add(0, 32, 3'b010, 1, 1);  add(5, 67, 3'b000, 1, 1);  add(5, 68, 3'b000, 0, 1);
    add(5, 75, 3'b000, 0, 1);  add(5, 76, 3'b000, 1, 1);  add(8, 32, 3'b000, 1, 1);
    add(19, 4, 3'b111, 1, 1);  add(21, 32, 3'b010, 1, 1); add(22, 31, 3'b110, 1, 1);
    add(23, 8, 3'b000, 1, 1);  add(23, 32, 3'b110, 1, 1); add(23, 34, 3'b000, 1, 1);
    add(23, 55, 3'b000, 1, 1); add(23, 56, 3'b111, 1, 1); add(23, 59, 3'b111, 1, 1);
    add(23, 60, 3'b000, 1, 1); add(24, 33, 3'b110, 1, 1); add(27, 7, 3'b111, 1, 1);
    add(28, 4, 3'b000, 1, 1);  add(49, 79, 3'b000, 1, 1); add(50, 10, 3'b000, 1, 0);
    add(51, 79, 3'b000, 1, 0); add(52, 0, 3'b000, 1, 1);
    f1 = nvec;
    // Frame 1: pl=2 (clipped), pr=40, ball (57,40) over right pad
    add(0, 4, 3'b000, 1, 1);   add(2, 56, 3'b000, 1, 1);  add(3, 56, 3'b111, 1, 1);
    add(7, 57, 3'b110, 1, 1);  add(7, 59, 3'b111, 1, 1);  add(7, 60, 3'b000, 1, 1);
    f1b = nvec;
    add(11, 59, 3'b111, 1, 1); add(12, 59, 3'b000, 1, 1); add(40, 4, 3'b000, 1, 1);
    add(41, 4, 3'b111, 1, 1);  add(47, 7, 3'b111, 1, 1);
    f2a = nvec;
    // Frame 2: pl=40, ball (0,10) at the left edge
    add(2, 4, 3'b000, 1, 1);   add(3, 4, 3'b111, 1, 1);   add(11, 7, 3'b111, 1, 1);
    add(36, 0, 3'b110, 1, 1);
    f2b = nvec;
    add(36, 1, 3'b110, 1, 1);  add(36, 2, 3'b000, 1, 1);  add(37, 1, 3'b110, 1, 1);
    add(37, 2, 3'b000, 1, 1);  add(38, 1, 3'b110, 1, 1);  add(39, 0, 3'b000, 1, 1);
    f2c = nvec;
    // After mid-frame reset: default snapshot again
    add(0, 32, 3'b010, 1, 1);  add(19, 4, 3'b111, 1, 1);  add(23, 32, 3'b110, 1, 1);
    f3 = nvec;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    // Inputs for frame 1 applied now; frame 0 must ignore them.
    pad_left = 12'd2; pad_right = 12'd40; ball_x = 12'd57; ball_y = 12'd40;
    rst = 1'b0;
    mh = 0; mv = 0;

    run_vec(0, f1);
    run_vec(f1, f1b);
    step_to(10, 0);
    pad_left = 12'd40; ball_x = 12'd0; ball_y = 12'd10;
    run_vec(f1b, f2a);
    run_vec(f2a, f2b);

    // Freeze mid-line on a ball pixel
    frz_rgb = rgb;
    pix_en = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (k % 10 == 0) begin
        chk("freeze_rgb", int'(rgb), int'(frz_rgb));
        chk("freeze_hsync", int'(hsync), 1);
        chk("freeze_frame_start", int'(frame_start), 0);
      end
    end
    run_vec(f2b, f2c);

    // Reset in the middle of an hsync pulse
    step_to(40, 70);
    pix();
    chk("pre_rst_hsync", int'(hsync), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_hsync", int'(hsync), 1);
    chk("midrst_rgb", int'(rgb), 0);
    chk("midrst_frame_start", int'(frame_start), 0);
    rst = 1'b0;
    mh = 0; mv = 0;
    run_vec(f2c, f3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
